// File: rtl/addsub4_arbiter.sv
// addsub4_arbiter: round-robin arbiter/sequencer sharing one 4-bit add/sub
// datapath between two requesters, with a registered valid/ready response.
// Optional build macro OVERFLOW_FLAG_EN adds the rsp_ovf signed-overflow output.
module addsub4_arbiter #(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req0_sub,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic       req1_sub,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_result,
  output logic       rsp_carry
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic       rsp_ovf
`endif
);

  localparam int unsigned DW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            prio_q, prio_d;
  logic [DW-1:0]   op_a_q, op_a_d;
  logic [DW-1:0]   op_b_q, op_b_d;
  logic            op_sub_q, op_sub_d;
  logic            op_id_q, op_id_d;
  logic            rsp_valid_d;
  logic            rsp_id_d;
  logic [DW-1:0]   rsp_result_d;
  logic            rsp_carry_d;
  logic [DW:0]     sum_c;
  logic [DW-1:0]   resultv_c;
  logic            cout_c;
  logic            grant1_c;
`ifdef OVERFLOW_FLAG_EN
  logic            rsp_ovf_d;
  logic            ovf_c;
`endif

  // addSub4 datapath: subtraction as A + ~B + 1, so cout is the no-borrow flag
  assign sum_c     = {1'b0, op_a_q} + {1'b0, op_b_q ^ {DW{op_sub_q}}} + (DW+1)'(op_sub_q);
  assign resultv_c = sum_c[DW-1:0];
  assign cout_c    = sum_c[DW];

`ifdef OVERFLOW_FLAG_EN
  // Signed overflow: operand signs (B inverted for sub) agree but result sign differs
  assign ovf_c = ((op_a_q[DW-1] ^ op_sub_q) == op_b_q[DW-1]) &&
                 (resultv_c[DW-1] != op_a_q[DW-1]);
`endif

  // Requester 1 wins when alone or when both are valid and it holds priority
  assign grant1_c = req1_valid && (!req0_valid || prio_q);

  // Next-state, handshake and register-update logic
  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_sub_d     = op_sub_q;
    op_id_d      = op_id_q;
    rsp_valid_d  = rsp_valid;
    rsp_id_d     = rsp_id;
    rsp_result_d = rsp_result;
    rsp_carry_d  = rsp_carry;
`ifdef OVERFLOW_FLAG_EN
    rsp_ovf_d    = rsp_ovf;
`endif
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (reset) begin
          req0_ready = req0_valid && !grant1_c;
          req1_ready = req1_valid && grant1_c;
        end
        if (req0_ready) begin
          op_a_d   = req0_a;
          op_b_d   = req0_b;
          op_sub_d = req0_sub;
          op_id_d  = 1'b0;
          prio_d   = 1'b1;
          state_d  = EXEC;
        end else if (req1_ready) begin
          op_a_d   = req1_a;
          op_b_d   = req1_b;
          op_sub_d = req1_sub;
          op_id_d  = 1'b1;
          prio_d   = 1'b0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = resultv_c;
        rsp_carry_d  = cout_c;
        rsp_id_d     = op_id_q;
        rsp_valid_d  = 1'b1;
`ifdef OVERFLOW_FLAG_EN
        rsp_ovf_d    = ovf_c;
`endif
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and register update; reset drops any transaction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      prio_q     <= PRIO_INIT;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_sub_q   <= 1'b0;
      op_id_q    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      rsp_ovf    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_sub_q   <= op_sub_d;
      op_id_q    <= op_id_d;
      rsp_valid  <= rsp_valid_d;
      rsp_id     <= rsp_id_d;
      rsp_result <= rsp_result_d;
      rsp_carry  <= rsp_carry_d;
`ifdef OVERFLOW_FLAG_EN
      rsp_ovf    <= rsp_ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_addsub4_arbiter.sv
// Self-checking bench for addsub4_arbiter: transaction-level model checked
// every cycle at the falling edge, directed scenarios plus randomized traffic.
// Honours OVERFLOW_FLAG_EN when the design is built with it.
module tb_addsub4_arbiter;

  localparam bit PRIO_INIT = 1'b0;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req0_sub;
  logic [3:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_sub;
  logic [3:0] req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_carry;
  logic [3:0] rsp_result;
`ifdef OVERFLOW_FLAG_EN
  logic       rsp_ovf;
`endif

  addsub4_arbiter #(.PRIO_INIT(PRIO_INIT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry)
`ifdef OVERFLOW_FLAG_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: at most one transaction in flight, its expected response and issue cycle
  bit outstanding = 1'b0;
  bit m_prio      = PRIO_INIT;
  int acc_cyc, exp_id, exp_res, exp_car, exp_ovf;
  bit g1, e0, e1, ev;
  int log_id[$], log_res[$], log_car[$], log_ovf[$], log_cyc[$];
  int acc_ids[$], acc_cycs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Plain-arithmetic definition of the operation
  function automatic void calc(input int a, input int b, input int sub,
                               output int res, output int car, output int ovf);
    int sa, sb, sr;
    sa  = (a >= 8) ? a - 16 : a;
    sb  = (b >= 8) ? b - 16 : b;
    res = sub ? ((a - b) & 15) : ((a + b) & 15);
    car = sub ? int'(a >= b) : int'(a + b > 15);
    sr  = sub ? sa - sb : sa + sb;
    ovf = int'(sr > 7 || sr < -8);
  endfunction

  // Compare process: outputs are stable here, inputs are held until the next rising edge
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_carry", rsp_carry, 0);
`ifdef OVERFLOW_FLAG_EN
      chk("rst_rsp_ovf", rsp_ovf, 0);
`endif
      outstanding = 1'b0;
      m_prio      = PRIO_INIT;
    end else begin
      g1 = req1_valid && (!req0_valid || m_prio);
      e0 = !outstanding && req0_valid && !g1;
      e1 = !outstanding && req1_valid && g1;
      ev = outstanding && (cyc >= acc_cyc + 2);
      chk("ready0", req0_ready, int'(e0));
      chk("ready1", req1_ready, int'(e1));
      chk("rsp_valid", rsp_valid, int'(ev));
      if (ev) begin
        chk("rsp_id", rsp_id, exp_id);
        chk("rsp_result", rsp_result, exp_res);
        chk("rsp_carry", rsp_carry, exp_car);
`ifdef OVERFLOW_FLAG_EN
        chk("rsp_ovf", rsp_ovf, exp_ovf);
`endif
        if (rsp_ready) begin
          outstanding = 1'b0;
          log_id.push_back(int'(rsp_id));
          log_res.push_back(int'(rsp_result));
          log_car.push_back(int'(rsp_carry));
`ifdef OVERFLOW_FLAG_EN
          log_ovf.push_back(int'(rsp_ovf));
`else
          log_ovf.push_back(0);
`endif
          log_cyc.push_back(cyc);
        end
      end
      if (e0 || e1) begin
        exp_id = e1 ? 1 : 0;
        if (e1) calc(int'(req1_a), int'(req1_b), int'(req1_sub), exp_res, exp_car, exp_ovf);
        else    calc(int'(req0_a), int'(req0_b), int'(req0_sub), exp_res, exp_car, exp_ovf);
        outstanding = 1'b1;
        acc_cyc     = cyc;
        m_prio      = ~e1;
        acc_ids.push_back(exp_id);
        acc_cycs.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_acc(input int n);
    int b = 0;
    while (acc_ids.size() < n && b < 60) begin step(); b++; end
    chk("accept_timeout", int'(acc_ids.size() >= n), 1);
  endtask

  task automatic wait_log(input int n);
    int b = 0;
    while (log_id.size() < n && b < 60) begin step(); b++; end
    chk("response_timeout", int'(log_id.size() >= n), 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
  endtask

  task automatic drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    repeat (6) step();
  endtask

  // One isolated operation on a chosen requester; the response is left in the log
  task automatic issue(input int id, input int a, input int b, input int sub);
    int base = log_id.size();
    int na   = acc_ids.size();
    rsp_ready = 1'b1;
    if (id == 0) begin
      req0_a = 4'(a); req0_b = 4'(b); req0_sub = sub[0]; req0_valid = 1'b1;
    end else begin
      req1_a = 4'(a); req1_b = 4'(b); req1_sub = sub[0]; req1_valid = 1'b1;
    end
    wait_acc(na + 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_log(base + 1);
  endtask

  int base, na;

  initial begin
    reset = 1'b0;
    {req0_valid, req0_sub, req1_valid, req1_sub, rsp_ready} = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (3) step();
    reset = 1'b1;
    step();

    // Single requester, 5+3
    base = log_id.size();
    issue(0, 5, 3, 0);
    chk("t1_id", log_id[base], 0);
    chk("t1_result", log_res[base], 8);
    chk("t1_carry", log_car[base], 0);
    chk("t1_latency", log_cyc[base] - acc_cycs[acc_cycs.size()-1], 2);

    // Simultaneous requests: 7+9 from 0, 2-5 from 1
    do_reset();
    base = log_id.size();
    na   = acc_ids.size();
    rsp_ready = 1'b1;
    req0_a = 4'd7; req0_b = 4'd9; req0_sub = 1'b0; req0_valid = 1'b1;
    req1_a = 4'd2; req1_b = 4'd5; req1_sub = 1'b1; req1_valid = 1'b1;
    wait_acc(na + 1);
    req0_valid = 1'b0;
    wait_acc(na + 2);
    req1_valid = 1'b0;
    wait_log(base + 2);
    chk("t2_first_id", log_id[base], 0);
    chk("t2_first_result", log_res[base], 0);
    chk("t2_first_carry", log_car[base], 1);
    chk("t2_second_id", log_id[base+1], 1);
    chk("t2_second_result", log_res[base+1], 13);
    chk("t2_second_carry", log_car[base+1], 0);
    drain();

    // Both continuously valid: alternating grants at full rate
    do_reset();
    base = log_id.size();
    na   = acc_ids.size();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_log(base + 4);
    for (int i = 0; i < 4; i++) chk("t3_grant_order", acc_ids[na+i], i % 2);
    for (int i = 1; i < 4; i++) chk("t3_spacing", log_cyc[base+i] - log_cyc[base+i-1], 3);
    drain();

    // Back-pressure in RESP with both requesters waiting
    do_reset();
    na = acc_ids.size();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_acc(na + 1);
    repeat (5) step();
    chk("t4_held_valid", rsp_valid, 1);
    chk("t4_held_ready", int'(req0_ready | req1_ready), 0);
    rsp_ready = 1'b1;
    wait_acc(na + 2);
    chk("t4_next_grant", acc_ids[na+1], 1);
    drain();

    // Reset during EXEC drops the transaction and restores priority
    do_reset();
    base = log_id.size();
    na   = acc_ids.size();
    rsp_ready = 1'b1;
    req0_a = 4'd5; req0_b = 4'd3; req0_sub = 1'b0; req0_valid = 1'b1;
    wait_acc(na + 1);
    reset = 1'b0;
    #1;
    chk("t5_valid_on_reset", rsp_valid, 0);
    req0_valid = 1'b0;
    step();
    reset = 1'b1;
    repeat (6) step();
    chk("t5_no_response", log_id.size(), base);
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_acc(na + 2);
    chk("t5_prio_restored", acc_ids[na+1], int'(PRIO_INIT));
    drain();

    // Wrap-around boundaries
    base = log_id.size();
    issue(0, 15, 1, 0);
    chk("wrap_add_result", log_res[base], 0);
    chk("wrap_add_carry", log_car[base], 1);
    issue(1, 0, 1, 1);
    chk("wrap_sub_result", log_res[base+1], 15);
    chk("wrap_sub_carry", log_car[base+1], 0);

`ifdef OVERFLOW_FLAG_EN
    base = log_id.size();
    issue(0, 7, 1, 0);
    chk("ovf_7p1_result", log_res[base], 8);
    chk("ovf_7p1", log_ovf[base], 1);
    issue(1, 8, 1, 1);
    chk("ovf_8m1_result", log_res[base+1], 7);
    chk("ovf_8m1", log_ovf[base+1], 1);
    issue(0, 3, 2, 0);
    chk("ovf_3p2", log_ovf[base+2], 0);
`endif

    // Randomized traffic, back-pressure and occasional resets
    base = log_id.size();
    for (int i = 0; i < 2000; i++) begin
      req0_valid = ($urandom_range(99) < 60);
      req1_valid = ($urandom_range(99) < 60);
      req0_a = 4'($urandom); req0_b = 4'($urandom); req0_sub = 1'($urandom);
      req1_a = 4'($urandom); req1_b = 4'($urandom); req1_sub = 1'($urandom);
      rsp_ready = ($urandom_range(99) < 70);
      reset = ($urandom_range(199) != 0);
      step();
    end
    reset = 1'b1;
    drain();
    chk("random_progress", int'(log_id.size() - base > 100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
